uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Initiator side of the UART programming port that feeds the upg_* write
//  interface of the data/instruction memories.
//  - Receives 8N1 serial bytes and assembles them little-endian into 32-bit words.
//  - Issues one-cycle word writes at incrementing word addresses.
//  - Raises upg_done_o after the announced word count, which hands the memories back to the CPU.
// PARAMETERS
//  CLK_FREQ   10_000_000  upg_clk_i frequency, Hz
//  BAUD       128_000     serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (>=4)
//  ADDR_W     14          word-address width of upg_adr_o
// PORTS
//  upg_clk_i    in   1       loader clock
//  upg_rstn_i   in   1       async active-low reset
//  prog_en_i    in   1       1 = programming session enabled; 0 = abort/idle
//  uart_rx_i    in   1       serial input, idle high, asynchronous to clock
//  upg_wen_o    out  1       one-cycle word write strobe
//  upg_adr_o    out  ADDR_W  word address of current write
//  upg_dat_o    out  32      write data {b3,b2,b1,b0}
//  upg_done_o   out  1       session complete; held until prog_en_i=0
//  upg_err_o    out  1       sticky: framing error or count > 2^ADDR_W
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; uart_rx synchroniser flops reset to 1.
//  RX path
//  - uart_rx_i goes through a 2-flop synchroniser.
//  - RX FSM states: IDLE -> START on a synchronised falling edge.
//  - START: counts CLKS_PER_BIT/2 and resamples. If high -> IDLE (glitch, no error); if low -> DATA.
//  - DATA: samples 8 bits, LSB first, every CLKS_PER_BIT -> STOP.
//  - STOP: samples one CLKS_PER_BIT later. If 1, byte_vld pulses for 1 cycle on the cycle after
//    the sample. If 0, ferr pulses; no byte. Then -> IDLE.
//  - RX runs only when prog_en_i=1; otherwise it is held in IDLE.
//  Loader FSM states: L_IDLE, L_HDR0, L_HDR1, L_DATA, L_DONE, L_ERR.
//  - L_IDLE: when prog_en_i=1 -> L_HDR0; word address and byte index clear to 0.
//  - L_HDR0/L_HDR1: capture count[7:0] then count[15:8] (word count N).
//  - On HDR1 byte: N==0 -> L_DONE; N>2^ADDR_W -> L_ERR; else -> L_DATA.
//  - L_DATA: each byte fills lane byte_idx (0..3) of the assembly register.
//  - On lane 3: cycle after byte_vld, upg_wen_o=1 for exactly 1 cycle with
//    upg_adr_o=word index and upg_dat_o=assembled word.
//  - Next cycle: word index +1, byte_idx->0.
//  - After the write of word N-1 -> L_DONE. upg_done_o=1 asserts in the cycle after that write strobe.
//  - L_DONE: further bytes ignored; upg_done_o held high.
//  - L_ERR: upg_err_o=1, upg_done_o=0, no writes; bytes ignored.
//  - Any ferr while in HDR0/HDR1/DATA -> L_ERR; the partial word is discarded.
//  - prog_en_i=0 in any state -> L_IDLE next cycle. This clears done, err, byte_idx
//    and the address, and drops wen (mid-session abort, no partial write).
//  - upg_adr_o/upg_dat_o hold the last written values between strobes; they are
//    meaningful only while upg_wen_o=1.
//  - Maximum N=2^ADDR_W. The last address is 2^ADDR_W-1; the index never wraps
//    because the FSM leaves L_DATA first.
//  - Byte throughput is bounded by UART; a byte_vld never coincides with a
//    write strobe of the same word, so no backpressure is needed.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit, ADDR_W=4)
//  1 Send 02 00 | 78 56 34 12 | EF BE AD DE -> wen pulses adr=0 dat=12345678,
//    then adr=1 dat=DEADBEEF; done=1 one cycle after 2nd strobe; err=0.
//  2 Header 00 00 -> done=1 with zero wen pulses; later bytes produce no wen.
//  3 Header 11 00 (N=17 > 16) -> err=1, done=0, no wen; prog_en_i=0 clears err.
//  4 N=1, second data byte sent with stop bit 0 -> err=1, no wen ever for that word.
//  5 3-clk low glitch on rx while idle -> no byte, no err; the following valid frame is received correctly.
//  6 N=16 full image: 16 strobes, adr 0..15 in order; drop prog_en_i mid-word of a
//    second session -> no wen, outputs clear, new session restarts at adr 0.

Source files
------------

// File: rtl/uart_prog_loader_if.sv
// uart_prog_loader_if: session control, serial input and memory write bus of the UART program loader.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic              prog_en_i;
    logic              uart_rx_i;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_adr_o;
    logic [31:0]       upg_dat_o;
    logic              upg_done_o;
    logic              upg_err_o;

    modport master (
        input  prog_en_i, uart_rx_i,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );

    modport slave (
        output prog_en_i, uart_rx_i,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o
    );
endinterface

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 receiver that assembles little-endian words from a counted
// byte stream and writes them to program memory at incrementing word addresses.
module uart_prog_loader #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 128_000,
    parameter int ADDR_W   = 14
) (
    input logic                upg_clk_i,
    input logic                upg_rstn_i,
    uart_prog_loader_if.master bus
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
    localparam logic [16:0]   MAX_N  = 17'(1) << ADDR_W;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] L_IDLE = 3'd0;
    localparam logic [2:0] L_HDR0 = 3'd1;
    localparam logic [2:0] L_HDR1 = 3'd2;
    localparam logic [2:0] L_DATA = 3'd3;
    localparam logic [2:0] L_DONE = 3'd4;
    localparam logic [2:0] L_ERR  = 3'd5;

    logic              r_rx_s1, r_rx_s2, r_rx_d;
    logic [1:0]        r_rstate;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_bvld, r_ferr;
    logic [2:0]        r_lstate;
    logic [15:0]       r_n;
    logic [1:0]        r_bidx;
    logic [ADDR_W-1:0] r_widx;
    logic [23:0]       r_asm;
    logic              r_wen, r_done, r_err;
    logic [ADDR_W-1:0] r_adr;
    logic [31:0]       r_dat;

    logic [15:0] w_n;
    logic        w_last;
    logic        w_en;

    assign w_en   = bus.prog_en_i;
    assign w_n    = {r_shift, r_n[7:0]};
    assign w_last = 16'(r_widx) == r_n - 16'd1;

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rstate <= R_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_bvld   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_rx_s1 <= bus.uart_rx_i;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_bvld  <= 1'b0;
            r_ferr  <= 1'b0;
            if (!w_en) begin
                r_rstate <= R_IDLE;
            end else begin
                case (r_rstate)
                    R_IDLE: begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        if (r_rx_d && !r_rx_s2) r_rstate <= R_START;
                    end
                    // mid-start-bit resample rejects short low glitches silently
                    R_START: begin
                        if (r_cnt == C_HALF) begin
                            r_cnt    <= '0;
                            r_rstate <= r_rx_s2 ? R_IDLE : R_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (r_cnt == C_FULL) begin
                            r_cnt   <= '0;
                            r_shift <= {r_rx_s2, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_rstate <= R_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (r_cnt == C_FULL) begin
                            r_bvld   <= r_rx_s2;
                            r_ferr   <= !r_rx_s2;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            r_lstate <= L_IDLE;
            r_n      <= '0;
            r_bidx   <= '0;
            r_widx   <= '0;
            r_asm    <= '0;
            r_wen    <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (!w_en) begin
                r_lstate <= L_IDLE;
                r_bidx   <= '0;
                r_widx   <= '0;
                r_adr    <= '0;
                r_done   <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                // status trails the state by a cycle so done follows the last strobe
                r_done <= r_lstate == L_DONE;
                r_err  <= r_lstate == L_ERR;
                case (r_lstate)
                    L_IDLE: begin
                        r_lstate <= L_HDR0;
                        r_bidx   <= '0;
                        r_widx   <= '0;
                    end
                    L_HDR0: begin
                        if (r_ferr) r_lstate <= L_ERR;
                        else if (r_bvld) begin
                            r_n[7:0] <= r_shift;
                            r_lstate <= L_HDR1;
                        end
                    end
                    L_HDR1: begin
                        if (r_ferr) r_lstate <= L_ERR;
                        else if (r_bvld) begin
                            r_n[15:8] <= r_shift;
                            r_lstate  <= (w_n == 16'd0) ? L_DONE : ({1'b0, w_n} > MAX_N) ? L_ERR : L_DATA;
                        end
                    end
                    L_DATA: begin
                        if (r_ferr) r_lstate <= L_ERR;
                        else if (r_bvld) begin
                            r_bidx <= r_bidx + 2'd1;
                            if (r_bidx == 2'd3) begin
                                r_wen  <= 1'b1;
                                r_adr  <= r_widx;
                                r_dat  <= {r_shift, r_asm};
                                r_widx <= r_widx + 1'b1;
                                if (w_last) r_lstate <= L_DONE;
                            end else begin
                                r_asm <= {r_shift, r_asm[23:8]};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.upg_wen_o  = r_wen;
    assign bus.upg_adr_o  = r_adr;
    assign bus.upg_dat_o  = r_dat;
    assign bus.upg_done_o = r_done;
    assign bus.upg_err_o  = r_err;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized and directed programming sessions checked against
// an expected write list derived from the header count and byte stream.
module tb_uart_prog_loader;
    localparam int CPB = 10;
    localparam int AW  = 4;

    typedef logic [7:0] bq_t[$];
    typedef bit         oq_t[$];

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_W(AW)) bus ();

    uart_prog_loader #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000),
        .ADDR_W  (AW)
    ) dut (
        .upg_clk_i (clk),
        .upg_rstn_i(rstn),
        .bus       (bus)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wen_cyc = -1;
    int done_cyc = -1;
    int long_wen = 0;
    logic prev_wen = 1'b0;
    logic prev_done = 1'b0;
    logic [35:0] got[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.upg_wen_o === 1'b1) begin
            got.push_back({bus.upg_adr_o, bus.upg_dat_o});
            last_wen_cyc = cyc;
            if (prev_wen) long_wen++;
        end
        if (bus.upg_done_o === 1'b1 && !prev_done) done_cyc = cyc;
        prev_wen  = bus.upg_wen_o;
        prev_done = bus.upg_done_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit okat(input oq_t ok, input int i);
        return i >= ok.size() || ok[i];
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit ok);
        bus.uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_rx_i = ok;
        repeat (CPB) @(negedge clk);
        bus.uart_rx_i = 1'b1;
        repeat (CPB + $urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic start_session();
        @(negedge clk);
        bus.prog_en_i = 1'b0;
        repeat (3) @(negedge clk);
        bus.prog_en_i = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string tag, input bq_t bytes, input oq_t ok, input bit glitch);
        logic [35:0] exp_w[$];
        bit e_done = 0;
        bit e_err = 0;
        int n = 0;
        int fb = bytes.size();
        int base;
        int ng;
        for (int i = bytes.size() - 1; i >= 0; i--)
            if (!okat(ok, i)) fb = i;
        if (fb < 2) begin
            e_err = fb < bytes.size();
        end else begin
            n = {bytes[1], bytes[0]};
            if (n == 0) e_done = 1;
            else if (n > (1 << AW)) e_err = 1;
            else begin
                for (int w = 0; w < n && 4 * w + 5 < fb; w++)
                    exp_w.push_back({4'(w), bytes[4*w+5], bytes[4*w+4], bytes[4*w+3], bytes[4*w+2]});
                e_done = exp_w.size() == n;
                e_err  = !e_done && fb < bytes.size();
            end
        end
        start_session();
        base = got.size();
        if (glitch) begin
            bus.uart_rx_i = 1'b0;
            repeat (3) @(negedge clk);
            bus.uart_rx_i = 1'b1;
            repeat (30) @(negedge clk);
            chk({tag, "_glitch_err"}, bus.upg_err_o, 1'b0);
        end
        foreach (bytes[i]) send_byte(bytes[i], okat(ok, i));
        repeat (40) @(negedge clk);
        ng = got.size() - base;
        chk({tag, "_nwr"}, ng, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < ng; i++)
            chk($sformatf("%s_wr%0d", tag, i), got[base+i], exp_w[i]);
        chk({tag, "_done"}, bus.upg_done_o, e_done);
        chk({tag, "_err"}, bus.upg_err_o, e_err);
        if (e_done && n > 0) chk({tag, "_done_lat"}, done_cyc - last_wen_cyc, 1);
    endtask

    initial begin
        bq_t b;
        oq_t o;
        int n;
        int base;
        bus.uart_rx_i = 1'b1;
        bus.prog_en_i = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wen", bus.upg_wen_o, 1'b0);
        chk("rst_adr", bus.upg_adr_o, 0);
        chk("rst_dat", bus.upg_dat_o, 0);
        chk("rst_done", bus.upg_done_o, 1'b0);
        chk("rst_err", bus.upg_err_o, 1'b0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        run("two_words", '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, '{}, 0);
        run("zero_cnt", '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, '{}, 0);
        run("over_cnt", '{8'h11, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, '{}, 0);
        bus.prog_en_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("over_cnt_clear", bus.upg_err_o, 1'b0);
        run("ferr_data", '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, '{1, 1, 1, 0, 1, 1}, 0);
        run("glitch", '{8'h01, 8'h00, 8'h5A, 8'hC3, 8'h0F, 8'h81}, '{}, 1);

        b = '{8'h10, 8'h00};
        for (int i = 0; i < 64; i++) b.push_back(8'($urandom));
        run("full", b, '{}, 0);

        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(1, 6);
            b = '{8'(n), 8'h00};
            for (int i = 0; i < 4 * n + $urandom_range(0, 3); i++) b.push_back(8'($urandom));
            o = '{};
            if (s == 3)
                for (int i = 0; i < b.size(); i++) o.push_back(i != 3 + 4 * $urandom_range(0, n - 1));
            run($sformatf("rnd%0d", s), b, o, 0);
        end
        n = $urandom_range(17, 65535);
        run("rnd_over", '{8'(n), 8'(n >> 8), 8'h01, 8'h02, 8'h03, 8'h04}, '{}, 0);

        start_session();
        base = got.size();
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        bus.prog_en_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_wen", bus.upg_wen_o, 1'b0);
        chk("abort_adr", bus.upg_adr_o, 0);
        chk("abort_done", bus.upg_done_o, 1'b0);
        chk("abort_err", bus.upg_err_o, 1'b0);
        chk("abort_nwr", got.size() - base, 0);
        run("restart", '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, '{}, 0);

        chk("wen_width", long_wen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
